// File: rtl/hvac_plant_scheduler_if.sv
// Zone-demand / plant-drive bundle for hvac_plant_scheduler.
// Level-signalled, no valid/ready: demands and enable are sampled every clock, all outputs are registered.
interface hvac_plant_scheduler_if #(
  parameter int NZ = 4
);
  logic          enable;
  logic [NZ-1:0] heat_req;
  logic [NZ-1:0] cool_req;
  logic          plant_heat;
  logic          plant_cool;
  logic [NZ-1:0] damper;
  logic          fan;
  logic [1:0]    state;

  modport master (
    output enable, heat_req, cool_req,
    input  plant_heat, plant_cool, damper, fan, state
  );

  modport slave (
    input  enable, heat_req, cool_req,
    output plant_heat, plant_cool, damper, fan, state
  );
endinterface

// File: rtl/hvac_plant_scheduler.sv
// Shares one heat/cool plant between NZ zones with min-run, max-run preemption and off-time lockout.
// Optional fan purge after each run: define HVAC_FAN_OVERRUN_EN.
module hvac_plant_scheduler #(
  parameter int NZ          = 4,
  parameter int CW          = 8,
  parameter int MIN_RUN     = 16,
  parameter int MAX_RUN     = 64,
  parameter int MIN_OFF     = 8,
  parameter int FAN_OVERRUN = 12
) (
  input logic                   clk,
  input logic                   reset,
  hvac_plant_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN_HEAT = 2'b01,
    RUN_COOL = 2'b10,
    LOCKOUT  = 2'b11
  } state_t;

  localparam logic [CW-1:0] MIN_RUN_C = CW'(MIN_RUN);
  localparam logic [CW-1:0] MAX_RUN_C = CW'(MAX_RUN);
  localparam logic [CW-1:0] MIN_OFF_C = CW'(MIN_OFF);

  state_t        state_q;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] off_cnt;
  logic          last_heat;
  logic          plant_heat_q;
  logic          plant_cool_q;
  logic [NZ-1:0] damper_q;
  logic          fan_q;

  logic [NZ-1:0] hv, cv, mine, other;
  logic [4:0]    hpop, cpop;
  logic          pick_heat, running, run_exit;
  logic          heat_nxt, cool_nxt, fan_nxt;

  function automatic logic [4:0] popcnt(input logic [NZ-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NZ; i++) n = n + {4'b0, v[i]};
    return n;
  endfunction

  always_comb begin
    hv        = bus.heat_req & ~bus.cool_req;
    cv        = bus.cool_req & ~bus.heat_req;
    hpop      = popcnt(hv);
    cpop      = popcnt(cv);
    // Tie goes to the mode that did not run last.
    pick_heat = (hpop > cpop) || ((hpop == cpop) && !last_heat);
    running   = (state_q == RUN_HEAT) || (state_q == RUN_COOL);
    mine      = (state_q == RUN_COOL) ? cv : hv;
    other     = (state_q == RUN_COOL) ? hv : cv;
    run_exit  = running && (!bus.enable ||
                ((run_cnt >= MIN_RUN_C) &&
                 ((mine == '0) || ((run_cnt >= MAX_RUN_C) && (other != '0)))));
    // enable gates the drives directly so a shutdown takes effect on the next edge.
    heat_nxt  = (state_q == RUN_HEAT) && bus.enable;
    cool_nxt  = (state_q == RUN_COOL) && bus.enable;
  end

`ifdef HVAC_FAN_OVERRUN_EN
  localparam logic [CW-1:0] FAN_OVERRUN_C = CW'(FAN_OVERRUN);
  logic [CW-1:0] ov_cnt;
  logic [CW-1:0] ov_nxt;

  // Purge window restarts on every run exit, including an enable shutdown.
  always_comb begin
    ov_nxt = ov_cnt;
    if (run_exit)            ov_nxt = FAN_OVERRUN_C;
    else if (ov_cnt != '0)   ov_nxt = ov_cnt - CW'(1);
    fan_nxt = heat_nxt | cool_nxt | (ov_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) ov_cnt <= '0;
    else       ov_cnt <= ov_nxt;
  end
`else
  always_comb fan_nxt = heat_nxt | cool_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      run_cnt      <= '0;
      off_cnt      <= '0;
      last_heat    <= 1'b0;
      plant_heat_q <= 1'b0;
      plant_cool_q <= 1'b0;
      damper_q     <= '0;
      fan_q        <= 1'b0;
    end else begin
      plant_heat_q <= heat_nxt;
      plant_cool_q <= cool_nxt;
      damper_q     <= heat_nxt ? hv : (cool_nxt ? cv : '0);
      fan_q        <= fan_nxt;
      case (state_q)
        IDLE: begin
          if (bus.enable && ((hv != '0) || (cv != '0))) begin
            state_q <= pick_heat ? RUN_HEAT : RUN_COOL;
            run_cnt <= CW'(1);
          end
        end
        RUN_HEAT, RUN_COOL: begin
          if (run_exit) begin
            state_q   <= LOCKOUT;
            off_cnt   <= CW'(1);
            run_cnt   <= '0;
            last_heat <= (state_q == RUN_HEAT);
          end else if (run_cnt != '1) begin
            run_cnt <= run_cnt + CW'(1);
          end
        end
        LOCKOUT: begin
          if (off_cnt >= MIN_OFF_C) begin
            state_q <= IDLE;
            off_cnt <= '0;
          end else begin
            off_cnt <= off_cnt + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.plant_heat = plant_heat_q;
  assign bus.plant_cool = plant_cool_q;
  assign bus.damper     = damper_q;
  assign bus.fan        = fan_q;
  assign bus.state      = state_q;

endmodule
